serial_byte_receiver: RTL and testbench
=======================================

# serial_byte_receiver

Receive-side counterpart of the SRAM dump path: takes the gated serial clock and bit stream produced by the capture board's readout (`ser_clk`, `ser_data`, framed by `ser_en`) and reassembles it into bytes. Bits arrive LSB first, eight per byte. Each completed byte is pushed into an internal first-word-fall-through FIFO, where downstream logic drains it with a simple read strobe. The block runs entirely in the `clk` domain and oversamples the serial clock.

## Interface
Parameters:
- `DATA_W`, 8: bits per received word.
- `DEPTH`, 16: FIFO entries; must be a power of 2.
- `SYNC_STAGES`, 2: synchronizer flops on `ser_clk`, `ser_data` and `ser_en`.

Ports:
- Clocking and reset: reset reset, synchronous, active-high; clock clk.
- `ser_clk` in 1: external serial clock. Data is valid on its rising edge. Its frequency must be ≤ clk/4.
- `ser_data` in 1: serial bit, LSB first.
- `ser_en` in 1: frame enable, high while a transfer is in progress.
- `rd_en` in 1: pop the FIFO head.
- `rd_data` out DATA_W: FIFO head. Reads 0 when the FIFO is empty.
- `empty` out 1: FIFO empty.
- `full` out 1: FIFO full.
- `overflow` out 1: sticky; set when a byte is dropped because the FIFO is full.
- `count` out $clog2(DEPTH)+1: number of FIFO entries.
- `bytes_rx` out 16: total bytes completed, including dropped ones; wraps at 0xFFFF to 0.
- `busy` out 1: FSM is in RECV.

## Operation
- All three serial inputs pass through SYNC_STAGES flops.
- An edge register on the synchronized `ser_clk` produces a one-cycle `edge_p` on each rising edge.
- FSM states and transitions:
  - IDLE → RECV when synchronized `ser_en`=1. On entry, `bit_cnt`=0.
  - RECV: on `edge_p`, shift in the synchronized `ser_data` as `sr = {bit, sr[DATA_W-1:1]}` and set `bit_cnt`+1.
  - RECV → PUSH on the `edge_p` with `bit_cnt`==DATA_W-1.
  - PUSH, one cycle: write `sr` to the FIFO and increment `bytes_rx`. If the FIFO is full, set `overflow` and drop the byte. Then `bit_cnt`=0 → RECV, or → IDLE if `ser_en` is low.
  - RECV → IDLE when synchronized `ser_en` drops. Partial bits are discarded without a push and without a `bytes_rx` increment.
- FIFO rules:
  - Pop happens on a cycle with `rd_en`=1 and `empty`=0.
  - `rd_en` while empty is ignored.
  - Push while full drops the byte, except when a pop happens in the same cycle: then both occur and `overflow` is not set.
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- `overflow` clears only on `reset`.
- `reset` mid-frame:
  - Returns to IDLE and clears `sr`, `bit_cnt`, the FIFO pointers, `count`, `bytes_rx` and `overflow`.
  - If `ser_en` is still high after reset, the FSM re-enters RECV and restarts at bit 0. Resynchronizing to byte boundaries is the sender's job.

## Timing
- Reset values: `rd_data`=0, `empty`=1, `full`=0, `overflow`=0, `count`=0, `bytes_rx`=0, `busy`=0.
- Raw `ser_clk` rise to `edge_p`: SYNC_STAGES+1 clk cycles. `ser_data` is delayed identically, so it must be stable for 1 clk before and after the `ser_clk` rise.
- 8th `edge_p` → PUSH on the next cycle. Then `empty` falls, `count` increments and `rd_data` is valid one cycle after PUSH.
- `rd_en` at edge N → `rd_data` shows the next entry, and `count` decrements, after edge N.
- `busy` rises SYNC_STAGES+1 cycles after raw `ser_en` rises.

## Structure
- `serial_rx_pkg` holds:
  - the state enum `rx_state_t` {IDLE, RECV, PUSH};
  - the default constants `RX_DATA_W`=8 and `RX_DEPTH`=16.
- The FIFO is a separate sub-module, `sync_fifo #(DATA_W, DEPTH)`, with FWFT behaviour and ports `push`, `pop`, `wdata`, `rdata`, `empty`, `full`, `count`.
- The synchronizer, edge detector, FSM and shift register live in the top module.

## Test plan
- Single byte: `ser_clk` = clk/8, send 0xA5 LSB first with `ser_en` high → `empty` falls; `rd_data`=0xA5, `count`=1, `bytes_rx`=1; after `rd_en`, `empty`=1.
- Stream: send 0x01..0x09, as the readout produces after a capture, and drain continuously → `rd_data` sequence 1..9 in order, `bytes_rx`=9, `overflow`=0.
- Fill and overflow: send 17 bytes, 0x10..0x20, with no reads → `full`=1 after 16 bytes, `overflow`=1, 0x20 dropped, `bytes_rx`=17; draining returns 0x10..0x1F.
- Simultaneous push/pop while full: pulse `rd_en` in the PUSH cycle of byte 17 → `overflow` stays 0, `count` stays 16.
- Aborted frame: drop `ser_en` after 5 bits, then send 0x3C → the only entry is 0x3C, `bytes_rx`=1.
- Reset mid-frame: assert `reset` after 3 bits with 2 bytes queued → all outputs at reset values; the following full byte 0x77 is received correctly.

Source files
------------

// File: rtl/serial_byte_receiver_pkg.sv
// ============================================================================
// serial_rx_pkg : shared types and default sizes for the serial byte receiver
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_rx_pkg;

    localparam int RX_DATA_W = 8;
    localparam int RX_DEPTH  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        PUSH = 2'd2
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/serial_byte_receiver_sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock first-word-fall-through FIFO
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo
    import serial_rx_pkg::*;
#(
    parameter int DATA_W = RX_DATA_W,
    parameter int DEPTH  = RX_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q;
    logic [AW-1:0]     rptr_q;
    logic [AW:0]       count_q;
    logic              w_pop;
    logic              w_push;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    // A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
    assign w_pop  = pop_i & ~empty_o;
    assign w_push = push_i & (~full_o | w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (w_push) wptr_q <= wptr_q + 1'b1;
            if (w_pop)  rptr_q <= rptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

`default_nettype wire

// File: rtl/serial_byte_receiver.sv
// ============================================================================
// serial_byte_receiver : oversampling LSB-first serial-to-byte receiver + FIFO
// Revision             : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_byte_receiver
    import serial_rx_pkg::*;
#(
    parameter int DATA_W      = RX_DATA_W,
    parameter int DEPTH       = RX_DEPTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ser_clk_i,
    input  logic                     ser_data_i,
    input  logic                     ser_en_i,
    input  logic                     rd_en_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     overflow_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [15:0]              bytes_rx_o,
    output logic                     busy_o
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // Bit order within each stage: {ser_en, ser_data, ser_clk}
    logic [2:0]        sync_q [SYNC_STAGES];
    logic              sclk_prev_q;
    logic              w_sclk;
    logic              w_sdat;
    logic              w_sen;
    logic              w_edge_p;

    rx_state_t         state_q,    state_d;
    logic [BW-1:0]     bit_cnt_q,  bit_cnt_d;
    logic [DATA_W-1:0] sr_q,       sr_d;
    logic [15:0]       bytes_rx_q, bytes_rx_d;
    logic              overflow_q, overflow_d;
    logic              w_push;
    logic              w_pop;

    assign w_sclk   = sync_q[SYNC_STAGES-1][0];
    assign w_sdat   = sync_q[SYNC_STAGES-1][1];
    assign w_sen    = sync_q[SYNC_STAGES-1][2];
    assign w_edge_p = w_sclk & ~sclk_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= {ser_en_i, ser_data_i, ser_clk_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sclk_prev_q <= w_sclk;
        end
    end

    assign w_push = (state_q == PUSH);
    assign w_pop  = rd_en_i & ~empty_o;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sr_d       = sr_q;
        bytes_rx_d = bytes_rx_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (w_sen) state_d = RECV;
            end
            RECV: begin
                // Losing the frame enable abandons any partial byte.
                if (!w_sen) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else if (w_edge_p) begin
                    sr_d      = {w_sdat, sr_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BW'(DATA_W-1)) state_d = PUSH;
                end
            end
            PUSH: begin
                bytes_rx_d = bytes_rx_q + 16'd1;
                if (full_o && !w_pop) overflow_d = 1'b1;
                bit_cnt_d  = '0;
                state_d    = w_sen ? RECV : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            sr_q       <= '0;
            bytes_rx_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_q       <= sr_d;
            bytes_rx_q <= bytes_rx_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_push),
        .pop_i   (rd_en_i),
        .wdata_i (sr_q),
        .rdata_o (rd_data_o),
        .empty_o (empty_o),
        .full_o  (full_o),
        .count_o (count_o)
    );

    assign overflow_o = overflow_q;
    assign bytes_rx_o = bytes_rx_q;
    assign busy_o     = (state_q == RECV);

endmodule

`default_nettype wire

// File: tb/tb_serial_byte_receiver.sv
// ============================================================================
// tb_serial_byte_receiver : randomized-rate stimulus against a queue model
// Revision                : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_byte_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        ser_clk;
    logic        ser_data;
    logic        ser_en;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        empty;
    logic        full;
    logic        overflow;
    logic [4:0]  count;
    logic [15:0] bytes_rx;
    logic        busy;

    serial_byte_receiver #(
        .DATA_W      (8),
        .DEPTH       (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ser_clk_i  (ser_clk),
        .ser_data_i (ser_data),
        .ser_en_i   (ser_en),
        .rd_en_i    (rd_en),
        .rd_data_o  (rd_data),
        .empty_o    (empty),
        .full_o     (full),
        .overflow_o (overflow),
        .count_o    (count),
        .bytes_rx_o (bytes_rx),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] exp_bytes;
    logic        exp_ovf;
    bit          stream_done;
    int          stream_reads;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Model: every completed byte counts; it is stored only if the FIFO has room.
    task automatic model_byte(input logic [7:0] b);
        exp_bytes = exp_bytes + 16'd1;
        if (exp_q.size() < 16) exp_q.push_back(b);
        else                   exp_ovf = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        exp_bytes = '0;
        exp_ovf   = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk_eq({tag, "_count"}, count, exp_q.size());
        chk_eq({tag, "_empty"}, empty, exp_q.size() == 0);
        chk_eq({tag, "_full"}, full, exp_q.size() == 16);
        chk_eq({tag, "_bytes"}, bytes_rx, exp_bytes);
        chk_eq({tag, "_ovf"}, overflow, exp_ovf);
    endtask

    task automatic send_bit(input logic b, input bit pop_in_push);
        int  h;
        bit  found;
        h        = $urandom_range(2, 4);
        ser_data = b;
        repeat (h) @(negedge clk);
        ser_clk = 1'b1;
        if (pop_in_push) begin
            found = 1'b0;
            for (int i = 0; i < 12 && !found; i++) begin
                @(negedge clk);
                if (!busy) found = 1'b1;
            end
            chk_eq("push_cycle_seen", found, 1'b1);
            if (found && exp_q.size() > 0) begin
                chk_eq("pp_rdata", rd_data, exp_q[0]);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
                void'(exp_q.pop_front());
            end
        end else begin
            repeat (h) @(negedge clk);
        end
        ser_clk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit pop_in_push);
        for (int i = 0; i < 8; i++) send_bit(b[i], pop_in_push && (i == 7));
        model_byte(b);
    endtask

    task automatic start_frame();
        ser_en = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_frame();
        repeat (2) @(negedge clk);
        ser_en = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic pop_check(input string tag);
        chk_eq({tag, "_notempty"}, empty, 1'b0);
        chk_eq(tag, rd_data, exp_q[0]);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        void'(exp_q.pop_front());
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) pop_check(tag);
        chk_eq({tag, "_empty_after"}, empty, 1'b1);
        chk_eq({tag, "_rdata_zero"}, rd_data, 8'h00);
    endtask

    initial begin
        reset    = 1'b1;
        ser_clk  = 1'b0;
        ser_data = 1'b0;
        ser_en   = 1'b0;
        rd_en    = 1'b0;
        exp_bytes = '0;
        exp_ovf   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk_eq("rst_rdata", rd_data, 8'h00);
        chk_eq("rst_busy", busy, 1'b0);
        check_state("rst");

        // Single byte
        start_frame();
        chk_eq("busy_in_frame", busy, 1'b1);
        send_byte(8'hA5, 1'b0);
        end_frame();
        chk_eq("single_rdata", rd_data, 8'hA5);
        check_state("single");
        drain("single");

        // Stream with a concurrent reader
        do_reset();
        stream_done  = 1'b0;
        stream_reads = 0;
        fork
            begin
                start_frame();
                for (int i = 1; i <= 9; i++) send_byte(i[7:0], 1'b0);
                end_frame();
                stream_done = 1'b1;
            end
            begin
                int c;
                for (c = 0; c < 4000 && !(stream_done && empty); c++) begin
                    @(negedge clk);
                    rd_en = 1'b0;
                    if (!empty) begin
                        if (exp_q.size() > 0) begin
                            chk_eq("stream_data", rd_data, exp_q[0]);
                            void'(exp_q.pop_front());
                            stream_reads++;
                        end else begin
                            chk_eq("stream_extra_entry", 1'b1, 1'b0);
                        end
                        rd_en = 1'b1;
                    end
                end
                chk_eq("stream_timeout", c < 4000, 1'b1);
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        chk_eq("stream_reads", stream_reads, 9);
        check_state("stream");

        // Fill and overflow
        do_reset();
        start_frame();
        for (int i = 0; i < 16; i++) send_byte(8'h10 + i[7:0], 1'b0);
        repeat (6) @(negedge clk);
        check_state("fill16");
        send_byte(8'h20, 1'b0);
        end_frame();
        check_state("fill17");
        drain("fill");
        chk_eq("ovf_sticky", overflow, 1'b1);

        // Simultaneous push and pop while full
        do_reset();
        start_frame();
        for (int i = 0; i < 16; i++) send_byte(8'h40 + i[7:0], 1'b0);
        send_byte(8'h50, 1'b1);
        end_frame();
        check_state("pushpop");
        drain("pushpop");

        // Aborted frame
        do_reset();
        start_frame();
        for (int i = 0; i < 5; i++) send_bit($urandom_range(0, 1), 1'b0);
        end_frame();
        start_frame();
        send_byte(8'h3C, 1'b0);
        end_frame();
        check_state("abort");
        drain("abort");

        // Reset mid-frame with entries queued
        do_reset();
        start_frame();
        send_byte(8'hC3, 1'b0);
        send_byte(8'h5A, 1'b0);
        for (int i = 0; i < 3; i++) send_bit($urandom_range(0, 1), 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        exp_bytes = '0;
        exp_ovf   = 1'b0;
        chk_eq("midrst_rdata", rd_data, 8'h00);
        chk_eq("midrst_busy", busy, 1'b0);
        check_state("midrst");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        send_byte(8'h77, 1'b0);
        end_frame();
        check_state("after_rst");
        drain("after_rst");

        // Random frames with random partial drains
        do_reset();
        for (int f = 0; f < 4; f++) begin
            int n;
            int k;
            n = $urandom_range(1, 20);
            start_frame();
            for (int i = 0; i < n; i++) send_byte($urandom_range(0, 255), 1'b0);
            end_frame();
            check_state("rand");
            k = $urandom_range(0, exp_q.size());
            for (int i = 0; i < k; i++) pop_check("rand_data");
        end
        drain("rand");
        check_state("rand_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
